// File: rtl/comparator_4_if.sv
// Operand/result bundle for comparator_4.
// master drives operands; slave returns the relation code.
interface comparator_4_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       c;
  logic             out_valid;

  modport master (
    output in_valid,
    output a,
    output b,
    input  c,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    output c,
    output out_valid
  );
endinterface

// File: rtl/comparator_4.sv
// Registered magnitude comparator, one-hot {gt,eq,lt} result.
// Define COMPARATOR_4_SIGNED_EN for two's complement operands.
module comparator_4 #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  comparator_4_if.slave  bus
);

  logic [WIDTH-1:0] a_w;
  logic [WIDTH-1:0] b_w;
  logic             gt;
  logic             eq;
  logic             lt;
  logic [2:0]       c_d;
  logic [2:0]       c_q;
  logic             v_d;
  logic             v_q;

  assign a_w = bus.a;
  assign b_w = bus.b;

  always_comb begin
    eq = (a_w == b_w);
`ifdef COMPARATOR_4_SIGNED_EN
    gt = ($signed(a_w) > $signed(b_w));
`else
    gt = (a_w > b_w);
`endif
    lt = ~gt & ~eq;
  end

  // c keeps the last result while no pair is offered
  always_comb begin
    c_d = c_q;
    v_d = bus.in_valid;
    if (bus.in_valid) begin
      c_d = {gt, eq, lt};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= 3'b000;
      v_q <= 1'b0;
    end else begin
      c_q <= c_d;
      v_q <= v_d;
    end
  end

  assign bus.c         = c_q;
  assign bus.out_valid = v_q;

endmodule

// File: tb/tb_comparator_4.sv
// Scoreboard bench for comparator_4: random, directed and
// exhaustive pairs checked against an integer relation model.
module tb_comparator_4;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [2:0] q[$];
  logic [2:0] cur_c;

  comparator_4_if #(.WIDTH(W)) bus ();

  comparator_4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string n, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               n, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] model(int x, int y);
    int sx;
    int sy;
    sx = x;
    sy = y;
`ifdef COMPARATOR_4_SIGNED_EN
    if (x >= (1 << (W - 1))) sx = x - (1 << W);
    if (y >= (1 << (W - 1))) sy = y - (1 << W);
`endif
    if (sx > sy) return 3'b100;
    if (sx == sy) return 3'b010;
    return 3'b001;
  endfunction

  // expected result is queued at the accepting edge
  always @(posedge clk) begin
    if (rst_n && bus.in_valid === 1'b1) begin
      q.push_back(model(int'(bus.a), int'(bus.b)));
    end
  end

  always @(negedge clk) begin
    chk("out_valid", int'(bus.out_valid), int'(q.size() > 0));
    if (q.size() > 0) cur_c = q.pop_front();
    chk("c", int'(bus.c), int'(cur_c));
    chk("onehot", int'(bus.c inside {3'b000, 3'b001,
                                     3'b010, 3'b100}), 1);
  end

  task automatic drive(logic v, int x, int y);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.a        = W'(x);
    bus.b        = W'(y);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    cur_c = 3'b000;
    #1;
    chk("rst_c", int'(bus.c), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cur_c = 3'b000;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #2;
    chk("reset_c", int'(bus.c), 0);
    chk("reset_valid", int'(bus.out_valid), 0);
    #11;
    rst_n = 1'b1;

    drive(1'b1, 0, 0);
    drive(1'b0, 0, 0);
    #1;
    chk("first_pair", int'(bus.c), 2);
    chk("first_valid", int'(bus.out_valid), 1);

    drive(1'b1, 1, 0);
    drive(1'b1, 0, 1);
    drive(1'b1, 10, 10);
    drive(1'b1, 5, 3);
    for (int i = 0; i < 3; i++) drive(1'b0, 0, 15);
    #1;
    chk("hold_c", int'(bus.c), 4);

    pulse_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 3, 1);

    drive(1'b1, 8, 7);
    drive(1'b0, 0, 0);
    #1;
`ifdef COMPARATOR_4_SIGNED_EN
    chk("msb_pair", int'(bus.c), 1);
`else
    chk("msb_pair", int'(bus.c), 4);
`endif

    for (int i = 0; i < (1 << W); i++)
      for (int j = 0; j < (1 << W); j++)
        drive(1'b1, i, j);

    for (int k = 0; k < 400; k++) begin
      drive(($urandom % 4) != 0,
            int'($urandom % (1 << W)),
            int'($urandom % (1 << W)));
      if (k == 200) pulse_reset();
    end

    for (int i = 0; i < 3; i++) drive(1'b0, 0, 0);
    @(negedge clk);
    #1;
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comparator_4.md
# comparator_4

Registered magnitude comparator for two 4-bit operands (width parameterisable). Each cycle it accepts a qualified operand pair and, one clock later, presents a one-hot relation code (greater / equal / less) with a matching valid flag. It is a leaf datapath block fed by upstream control logic; consumers sample `c` when `out_valid` is high.

## Interface
- `WIDTH`, default 4: operand width in bits; legal range 1–32.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  high when `a`/`b` carry an operand pair to compare this cycle.
- `a`  input  WIDTH  first operand.
- `b`  input  WIDTH  second operand.
- `c`  output  3  one-hot relation code, registered: `c[2]` = a>b, `c[1]` = a==b, `c[0]` = a<b.
- `out_valid`  output  1  registered; high for exactly one cycle per accepted pair.

## Operation
- Comparison is unsigned by default. With the signed option compiled in (see Configuration), operands are two's complement.
- On a rising edge with `in_valid`=1:
  - `c` loads exactly one of 3'b100, 3'b010 or 3'b001, from the relation of `a` and `b` at that edge.
  - `out_valid` loads 1.
- On a rising edge with `in_valid`=0:
  - `c` holds its last value.
  - `out_valid` loads 0.
- `c` is never 3'b011, 3'b101, 3'b110 or 3'b111. It is 3'b000 only from reset until the first accepted pair.
- No backpressure. Every pair presented with `in_valid` high is accepted; back-to-back pairs produce back-to-back results.
- Operand values on cycles with `in_valid` low are ignored.
- Equality is bitwise over all WIDTH bits. With WIDTH=1, the compare is 1 vs 0.

## Timing
- Latency: exactly 1 clock, from the accepting edge to `c`/`out_valid` valid. Throughput: one pair per clock.
- Reset (`rst_n`=0), asynchronous, takes effect immediately without a clock edge:
  - `c` = 3'b000.
  - `out_valid` = 0.
- Release of `rst_n` may be asynchronous to `clk`. The first edge at which `rst_n` is sampled high may accept a pair.
- Reset asserted mid-stream discards any result not yet presented. Results accepted before reset are not replayed after it.
- No combinational path from any input to any output.

## Configuration
- Macro `COMPARATOR_4_SIGNED_EN`.
- Defined: `a` and `b` compare as signed two's complement. Example: 4'b1000 (−8) < 4'b0111 (+7).
- Undefined (default): unsigned compare. Example: 4'b1000 (8) > 4'b0111 (7).
- Equality behaviour is identical in both builds.

## Test plan
- Reset, then `in_valid`=1, a=4'b0000, b=4'b0000 -> next cycle `c`=3'b010, `out_valid`=1.
- Back-to-back pairs (a,b) = (0001,0000), (0000,0001), (1010,1010) -> on three consecutive cycles `c` = 3'b100, 3'b001, 3'b010, with `out_valid` high on each.
- `in_valid`=1 with a=0101, b=0011, then `in_valid`=0 for 3 cycles with a=0000, b=1111 -> `c` holds 3'b100 throughout; `out_valid` is 1 then 0,0,0.
- `rst_n` pulsed low between clock edges while `c`=3'b100 -> `c`=3'b000 and `out_valid`=0 immediately; both stay so until a new pair is accepted.
- a=4'b1000, b=4'b0111 -> `c`=3'b100 without the macro; `c`=3'b001 with `COMPARATOR_4_SIGNED_EN` defined.
- Exhaustive sweep of all 256 (a,b) pairs in both builds -> `c` matches the reference relation and is always one-hot.
